// File: rtl/lite16_control.sv
// LITE-16 multi-cycle fetch/decode/execute controller.
// Owns the PC, sequences instruction/data memory handshakes and drives the ALU control word.
module lite16_control #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [2:0]  LINK_REG = 3'd7
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic [15:0] rd_data,
  input  logic        cmp,
  output logic [2:0]  alu_codeop,
  output logic        alu_ri,
  output logic        alu_ld,
  output logic        alu_jmp,
  output logic        b_sel_imm,
  output logic [15:0] imm,
  output logic [2:0]  rs1_addr,
  output logic [2:0]  rs2_addr,
  output logic [2:0]  rd_addr,
  output logic        rf_we,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [1:0] ClsR   = 2'b00;
  localparam logic [1:0] ClsRi  = 2'b01;
  localparam logic [1:0] ClsMem = 2'b10;
  localparam logic [1:0] ClsBr  = 2'b11;

  localparam logic [15:0] HaltWord = 16'hFFFF;

  state_e      r_state;
  logic [15:0] r_ir;
  logic [15:0] r_target;
  logic [15:0] r_pc;

  logic [1:0]  w_class;
  logic [2:0]  w_op;
  logic        w_is_ri;
  logic        w_is_mem;
  logic        w_is_br;
  logic        w_is_link;
  logic [15:0] w_pc_inc;

  assign w_class   = r_ir[15:14];
  assign w_op      = r_ir[13:11];
  assign w_is_ri   = (w_class == ClsRi);
  assign w_is_mem  = (w_class == ClsMem);
  assign w_is_br   = (w_class == ClsBr);
  assign w_is_link = w_is_br & w_op[2];
  assign w_pc_inc  = r_pc + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StFetch;
      r_ir     <= '0;
      r_target <= '0;
      r_pc     <= RESET_PC;
    end else begin
      case (r_state)
        StFetch: begin
          if (imem_ack) begin
            r_ir    <= imem_data;
            r_state <= StDecode;
          end
        end
        StDecode: begin
          r_state <= (r_ir == HaltWord) ? StHalt : StExec;
        end
        StExec: begin
          case (w_class)
            ClsR, ClsRi: r_state <= StWb;
            ClsMem:      r_state <= StMem;
            default: begin
              if (cmp) begin
                // Target is captured here so a link into the same register uses the old value.
                r_target <= rd_data;
                if (w_is_link) begin
                  r_state <= StWb;
                end else begin
                  r_pc    <= rd_data;
                  r_state <= StFetch;
                end
              end else begin
                r_pc    <= w_pc_inc;
                r_state <= StFetch;
              end
            end
          endcase
        end
        StMem: begin
          if (dmem_ack) begin
            if (w_op[0]) begin
              r_pc    <= w_pc_inc;
              r_state <= StFetch;
            end else begin
              r_state <= StWb;
            end
          end
        end
        StWb: begin
          r_pc    <= w_is_br ? r_target : w_pc_inc;
          r_state <= StFetch;
        end
        StHalt: begin
          r_state <= StHalt;
        end
        default: begin
          r_state <= StFetch;
        end
      endcase
    end
  end

  // Request is masked by rst_n so it stays low while reset is held even though state is FETCH.
  assign imem_req  = (r_state == StFetch) & rst_n;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign dmem_req  = (r_state == StMem);
  assign dmem_we   = dmem_req & w_op[0];
  assign rf_we     = (r_state == StWb);
  assign alu_ld    = rf_we & w_is_mem;
  assign alu_jmp   = rf_we & w_is_br;
  assign halted    = (r_state == StHalt);

  always_comb begin
    alu_codeop = w_op;
    alu_ri     = w_is_ri;
    b_sel_imm  = w_is_ri | w_is_mem;
    imm        = '0;
    rs1_addr   = r_ir[7:5];
    rs2_addr   = r_ir[4:2];
    rd_addr    = r_ir[10:8];
    case (w_class)
      ClsRi: begin
        imm      = {8'h00, r_ir[7:0]};
        rs1_addr = '0;
        rs2_addr = '0;
      end
      ClsMem: begin
        imm        = {11'h000, r_ir[4:0]};
        alu_codeop = 3'b000;
      end
      default: begin
        imm = '0;
      end
    endcase
    if (alu_jmp) begin
      rd_addr = LINK_REG;
    end
  end

endmodule

// File: tb/tb_lite16_control.sv
// Scoreboarded bench for lite16_control: random programs served by memory responders,
// expectations from an instruction-level model, checked by an independent monitor.
module tb_lite16_control;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [2:0]  LINK_REG = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic [15:0] rd_data = '0;
  logic        cmp = 1'b0;
  logic [2:0]  alu_codeop;
  logic        alu_ri;
  logic        alu_ld;
  logic        alu_jmp;
  logic        b_sel_imm;
  logic [15:0] imm;
  logic [2:0]  rs1_addr;
  logic [2:0]  rs2_addr;
  logic [2:0]  rd_addr;
  logic        rf_we;
  logic [15:0] pc;
  logic        halted;

  lite16_control #(
    .RESET_PC(RESET_PC),
    .LINK_REG(LINK_REG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .rd_data   (rd_data),
    .cmp       (cmp),
    .alu_codeop(alu_codeop),
    .alu_ri    (alu_ri),
    .alu_ld    (alu_ld),
    .alu_jmp   (alu_jmp),
    .b_sel_imm (b_sel_imm),
    .imm       (imm),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .rf_we     (rf_we),
    .pc        (pc),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] instr;
    logic        cmp;
    logic [15:0] rdd;
    int          iw;
    int          dw;
  } stim_t;

  typedef struct {
    logic [15:0] addr;
    int          start;
  } fetch_t;

  typedef struct {
    logic [2:0]  rd;
    logic        ld;
    logic        jmp;
    logic        ri;
    logic        bsel;
    logic [2:0]  op;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        chk_rs2;
    logic [15:0] imm;
    logic        chk_imm;
    logic [15:0] pc;
    int          at;
  } wb_t;

  typedef struct {
    logic        we;
    logic [2:0]  base;
    logic [15:0] imm;
    int          at;
    int          len;
  } mem_t;

  stim_t  stim_q[$];
  fetch_t fetch_q[$];
  wb_t    wb_q[$];
  mem_t   mem_q[$];

  int errors = 0;
  int checks = 0;
  logic [15:0] m_pc = RESET_PC;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic stim_t mk(input logic [15:0] instr, input logic c, input logic [15:0] rdd,
                               input int iw, input int dw);
    stim_t s;
    s.instr = instr;
    s.cmp   = c;
    s.rdd   = rdd;
    s.iw    = iw;
    s.dw    = dw;
    return s;
  endfunction

  // Instruction-level model: what one instruction fetched at cycle c must cause, and when.
  function automatic void model_step(input stim_t s, input int c);
    logic [1:0]  cls;
    logic [2:0]  op;
    logic [15:0] nxt;
    int          lat;
    wb_t         w;
    mem_t        m;
    fetch_t      f;
    if (s.instr == 16'hFFFF) return;
    cls       = s.instr[15:14];
    op        = s.instr[13:11];
    nxt       = m_pc + 16'd1;
    w.rd      = s.instr[10:8];
    w.ld      = 1'b0;
    w.jmp     = 1'b0;
    w.ri      = (cls == 2'd1);
    w.bsel    = (cls == 2'd1) || (cls == 2'd2);
    w.op      = (cls == 2'd2) ? 3'd0 : op;
    w.rs1     = (cls == 2'd1) ? 3'd0 : s.instr[7:5];
    w.rs2     = (cls == 2'd1) ? 3'd0 : s.instr[4:2];
    w.chk_rs2 = (cls != 2'd2);
    w.imm     = (cls == 2'd1) ? {8'h00, s.instr[7:0]} : {11'h000, s.instr[4:0]};
    w.chk_imm = (cls == 2'd1) || (cls == 2'd2);
    w.pc      = m_pc;
    w.at      = c + 3;
    lat       = 3;
    case (cls)
      2'd0, 2'd1: begin
        wb_q.push_back(w);
        lat = 4;
      end
      2'd2: begin
        m.we   = op[0];
        m.base = s.instr[7:5];
        m.imm  = {11'h000, s.instr[4:0]};
        m.at   = c + 3 + s.dw;
        m.len  = s.dw + 1;
        mem_q.push_back(m);
        if (op[0]) begin
          lat = 4 + s.dw;
        end else begin
          w.ld = 1'b1;
          w.at = c + 4 + s.dw;
          wb_q.push_back(w);
          lat = 5 + s.dw;
        end
      end
      default: begin
        if (s.cmp) begin
          nxt = s.rdd;
          if (op[2]) begin
            w.rd  = LINK_REG;
            w.jmp = 1'b1;
            wb_q.push_back(w);
            lat = 4;
          end
        end
      end
    endcase
    f.addr  = nxt;
    f.start = c + lat;
    fetch_q.push_back(f);
    m_pc = nxt;
  endfunction

  // Memory responders; stray acks are thrown in whenever the matching request is low.
  initial begin
    stim_t s;
    int icnt;
    int dcnt;
    int dwait;
    icnt  = 0;
    dcnt  = 0;
    dwait = 0;
    forever begin
      @(posedge clk);
      #1;
      imem_ack  = 1'b0;
      dmem_ack  = 1'b0;
      imem_data = 16'($urandom);
      if (!rst_n) begin
        icnt = 0;
        dcnt = 0;
        continue;
      end
      if (imem_req) begin
        if (stim_q.size() > 0) begin
          if (icnt >= stim_q[0].iw) begin
            s         = stim_q.pop_front();
            imem_ack  = 1'b1;
            imem_data = s.instr;
            cmp       = s.cmp;
            rd_data   = s.rdd;
            dwait     = s.dw;
            icnt      = 0;
            model_step(s, cyc);
          end else begin
            icnt++;
          end
        end
      end else begin
        icnt     = 0;
        imem_ack = 1'($urandom_range(0, 1));
      end
      if (dmem_req) begin
        if (dcnt >= dwait) begin
          dmem_ack = 1'b1;
          dcnt     = 0;
        end else begin
          dcnt++;
        end
      end else begin
        dcnt     = 0;
        dmem_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a fetch, data access or writeback.
  initial begin
    logic   prev_req;
    int     dlen;
    fetch_t f;
    wb_t    w;
    mem_t   m;
    prev_req = 1'b0;
    dlen     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        dlen     = 0;
        continue;
      end
      if (imem_req && !prev_req) begin
        chk("fetch_expected", 32'(fetch_q.size() != 0), 32'd1);
        if (fetch_q.size() != 0) begin
          f = fetch_q.pop_front();
          chk("fetch_addr", 32'(imem_addr), 32'(f.addr));
          chk("fetch_cycle", 32'(cyc), 32'(f.start));
        end
      end
      prev_req = imem_req;
      if (dmem_req) dlen++;
      else dlen = 0;
      if (dmem_req && dmem_ack) begin
        chk("mem_expected", 32'(mem_q.size() != 0), 32'd1);
        if (mem_q.size() != 0) begin
          m = mem_q.pop_front();
          chk("mem_we", 32'(dmem_we), 32'(m.we));
          chk("mem_base", 32'(rs1_addr), 32'(m.base));
          chk("mem_imm", 32'(imm), 32'(m.imm));
          chk("mem_codeop", 32'(alu_codeop), 32'd0);
          chk("mem_bsel", 32'(b_sel_imm), 32'd1);
          chk("mem_cycle", 32'(cyc), 32'(m.at));
          chk("mem_req_len", 32'(dlen), 32'(m.len));
        end
      end
      if (rf_we) begin
        chk("wb_expected", 32'(wb_q.size() != 0), 32'd1);
        if (wb_q.size() != 0) begin
          w = wb_q.pop_front();
          chk("wb_rd", 32'(rd_addr), 32'(w.rd));
          chk("wb_ld", 32'(alu_ld), 32'(w.ld));
          chk("wb_jmp", 32'(alu_jmp), 32'(w.jmp));
          chk("wb_ri", 32'(alu_ri), 32'(w.ri));
          chk("wb_bsel", 32'(b_sel_imm), 32'(w.bsel));
          chk("wb_codeop", 32'(alu_codeop), 32'(w.op));
          chk("wb_rs1", 32'(rs1_addr), 32'(w.rs1));
          if (w.chk_rs2) chk("wb_rs2", 32'(rs2_addr), 32'(w.rs2));
          if (w.chk_imm) chk("wb_imm", 32'(imm), 32'(w.imm));
          chk("wb_pc", 32'(pc), 32'(w.pc));
          chk("wb_cycle", 32'(cyc), 32'(w.at));
        end
      end
    end
  end

  task automatic release_reset();
    fetch_t f;
    @(posedge clk);
    #3;
    f.addr  = RESET_PC;
    f.start = cyc;
    fetch_q.push_back(f);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(posedge clk);
    #1;
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic clear_model();
    fetch_q.delete();
    wb_q.delete();
    mem_q.delete();
    stim_q.delete();
    m_pc = RESET_PC;
  endtask

  initial begin
    logic [15:0] r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_alu_ld", 32'(alu_ld), 32'd0);
    chk("rst_alu_jmp", 32'(alu_jmp), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc), 32'(RESET_PC));

    stim_q.push_back(mk(16'h0AA4, 1'b0, 16'h0000, 0, 0));
    stim_q.push_back(mk(16'h4D12, 1'b0, 16'h0000, 1, 0));
    stim_q.push_back(mk(16'h81A3, 1'b0, 16'h0000, 0, 3));
    stim_q.push_back(mk(16'h89A3, 1'b0, 16'h0000, 0, 0));
    stim_q.push_back(mk(16'hE324, 1'b1, 16'h0040, 0, 0));
    stim_q.push_back(mk(16'hE324, 1'b0, 16'h1234, 0, 0));
    stim_q.push_back(mk(16'hC000, 1'b1, 16'hFFFF, 0, 0));
    stim_q.push_back(mk(16'h0AA4, 1'b0, 16'h0000, 0, 0));
    for (int i = 0; i < 150; i++) begin
      r = 16'($urandom);
      if (r == 16'hFFFF) r = 16'h0000;
      stim_q.push_back(mk(r, 1'($urandom_range(0, 1)), 16'($urandom),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 3))));
    end
    stim_q.push_back(mk(16'hFFFF, 1'b0, 16'h0000, 0, 0));
    release_reset();
    wait_halt(20000);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_quiet", 32'({imem_req, dmem_req, rf_we}), 32'd0);
      chk("halt_held", 32'(halted), 32'd1);
    end
    chk("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);

    // Reset out of HALT, then again in the middle of a stalled load.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_from_halt_halted", 32'(halted), 32'd0);
    chk("rst_from_halt_req", 32'(imem_req), 32'd0);
    clear_model();
    stim_q.push_back(mk(16'h81A3, 1'b0, 16'h0000, 0, 1000));
    release_reset();
    for (int i = 0; i < 50 && !dmem_req; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_mem_req_high", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_mem_req_drop", 32'(dmem_req), 32'd0);
    chk("mid_mem_we_drop", 32'(dmem_we), 32'd0);
    chk("mid_mem_pc", 32'(pc), 32'(RESET_PC));
    chk("mid_mem_rf_we", 32'(rf_we), 32'd0);
    clear_model();
    stim_q.push_back(mk(16'h0AA4, 1'b0, 16'h0000, 0, 0));
    stim_q.push_back(mk(16'hFFFF, 1'b0, 16'h0000, 0, 0));
    release_reset();
    #1;
    chk("release_fetch_req", 32'(imem_req), 32'd1);
    chk("release_fetch_addr", 32'(imem_addr), 32'(RESET_PC));
    wait_halt(100);
    chk("final_fetch_q", 32'(fetch_q.size()), 32'd0);
    chk("final_wb_q", 32'(wb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
